// File: rtl/avalon_timer_if.sv
// Private Avalon-MM bus between the timer host (master) and one interval-timer slave.
// No waitrequest; read data is valid the cycle after the address is presented.
interface avalon_timer_if;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;

  modport master (
    output m_address, m_chipselect, m_write_n, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_write_n, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/avalon_timer_host.sv
// Avalon-MM initiator that programs a 16-bit interval timer and services its timeouts.
// Define TIMER_HOST_SNAP_EN to enable snapshot readback (snap_req/snap_valid/snap_value).
module avalon_timer_host #(
  parameter int TICK_W     = 32,
  parameter int CONTINUOUS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  output logic              busy,
  output logic              cfg_error,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  input  logic              irq_in,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  avalon_timer_if.master    m
);

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_CONTROL  = 3'd1;
  localparam logic [2:0] A_PERIOD_L = 3'd2;
  localparam logic [2:0] A_PERIOD_H = 3'd3;
  localparam logic [2:0] A_SNAP_L   = 3'd4;
  localparam logic [2:0] A_SNAP_H   = 3'd5;

  // START|ITO plus CONT when free-running; STOP with ITO cleared to quiesce the slave.
  localparam logic [15:0] CTRL_RUN  = (CONTINUOUS != 0) ? 16'h0007 : 16'h0005;
  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, CLR_FINAL,
    SNAP_WR, SNAP_RL, SNAP_RH
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, wn: 1'b1, addr: 3'd0, data: 16'h0000};

  function automatic bus_t bus_write(input logic [2:0] a, input logic [15:0] d);
    return '{cs: 1'b1, wn: 1'b0, addr: a, data: d};
  endfunction

  function automatic bus_t bus_read(input logic [2:0] a);
    return '{cs: 1'b1, wn: 1'b1, addr: a, data: 16'h0000};
  endfunction

  state_t      state;
  bus_t        bus;
  logic [15:0] period_hi;
  logic        start_ok;

  assign start_ok = (state == IDLE) && cfg_start && (cfg_period != 32'd0);

  assign m.m_chipselect = bus.cs;
  assign m.m_write_n    = bus.wn;
  assign m.m_address    = bus.addr;
  assign m.m_writedata  = bus.data;

  // The low half goes straight out on the accept edge; only the high half needs holding.
  always_ff @(posedge clk) begin
    if (start_ok) period_hi <= cfg_period[31:16];
  end

  // Bus register always carries the cycle belonging to the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bus        <= BUS_IDLE;
      busy       <= 1'b0;
      cfg_error  <= 1'b0;
      tick_pulse <= 1'b0;
      tick_count <= '0;
    end else begin
      bus        <= BUS_IDLE;
      cfg_error  <= 1'b0;
      tick_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_period == 32'd0) begin
              cfg_error <= 1'b1;
            end else begin
              tick_count <= '0;
              busy       <= 1'b1;
              state      <= WR_PL;
              bus        <= bus_write(A_PERIOD_L, cfg_period[15:0]);
            end
          end
        end
        WR_PL: begin
          state <= WR_PH;
          bus   <= bus_write(A_PERIOD_H, period_hi);
        end
        WR_PH: begin
          state <= WR_CTRL;
          bus   <= bus_write(A_CONTROL, CTRL_RUN);
        end
        WR_CTRL: state <= RUN;
        RUN: begin
          if (cfg_stop) begin
            state <= WR_STOP;
            bus   <= bus_write(A_CONTROL, CTRL_STOP);
          end else if (irq_in) begin
            state      <= CLR_ST;
            bus        <= bus_write(A_STATUS, 16'h0000);
            tick_pulse <= 1'b1;
            tick_count <= tick_count + TICK_W'(1);
          end
`ifdef TIMER_HOST_SNAP_EN
          else if (snap_req) begin
            state <= SNAP_WR;
            bus   <= bus_write(A_SNAP_L, 16'h0000);
          end
`endif
        end
        CLR_ST: begin
          if (CONTINUOUS != 0) begin
            state <= RUN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WR_STOP: begin
          state <= CLR_FINAL;
          bus   <= bus_write(A_STATUS, 16'h0000);
        end
        CLR_FINAL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        SNAP_WR: begin
          state <= SNAP_RL;
          bus   <= bus_read(A_SNAP_L);
        end
        SNAP_RL: begin
          state <= SNAP_RH;
          bus   <= bus_read(A_SNAP_H);
        end
        SNAP_RH: state <= RUN;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TIMER_HOST_SNAP_EN
  logic        snap_pend;
  logic [15:0] snap_lo;

  // Low half arrives during SNAP_RH, high half during the RUN cycle that follows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pend  <= 1'b0;
      snap_lo    <= 16'h0000;
      snap_valid <= 1'b0;
      snap_value <= 32'd0;
    end else begin
      snap_valid <= 1'b0;
      snap_pend  <= (state == SNAP_RH);
      if (state == SNAP_RH) snap_lo <= m.m_readdata;
      if (snap_pend) begin
        snap_value <= {m.m_readdata, snap_lo};
        snap_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_snap;
  assign unused_snap = snap_req ^ (^m.m_readdata);
  assign snap_valid  = 1'b0;
  assign snap_value  = 32'd0;
`endif

endmodule

// File: doc/avalon_timer_host.md
Name: avalon_timer_host

Overview:
Hardware Avalon-MM initiator that drives the 16-bit interval-timer slave without CPU involvement. Given a 32-bit period and start/stop commands, it programs the timer's period and control registers and services its interrupt by clearing status. It emits one tick pulse per timeout and keeps a running tick count. It sits between fabric-level control logic and a timer slave instance on a private bus: no arbiter, no waitrequest, fixed 1-cycle read latency.

Parameters:
TICK_W, 32, width of tick_count (2..32)
CONTINUOUS, 1, 1 = timer runs continuous (CONT bit set); 0 = one-shot, return to IDLE after first tick

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_period  in  32  timer period value; sampled on accepted cfg_start
cfg_start  in  1  start request, level sampled each clk
cfg_stop  in  1  stop request, level sampled each clk
busy  out  1  high whenever FSM not in IDLE
cfg_error  out  1  one-cycle pulse: start rejected (period 0)
tick_pulse  out  1  one-cycle pulse per serviced timeout
tick_count  out  TICK_W  serviced timeouts since last accepted start; wraps
m_address  out  3  slave word address
m_chipselect  out  1  slave select
m_write_n  out  1  active-low write
m_writedata  out  16  write data
m_readdata  in  16  slave read data, valid the cycle after address presented
irq_in  in  1  timer interrupt, level

Behaviour:
- Reset: clk / reset_n (async, active-low). Reset also restarts the FSM mid-transaction; no bus cleanup. All outputs reset to 0, except m_write_n = 1.
- All bus outputs are registered. Each FSM state other than IDLE/RUN drives exactly one bus cycle (single clk, no wait).
- Idle bus: chipselect 0, write_n 1, address 0, writedata 0.
- Addresses: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- States: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, CLR_FINAL.
- IDLE, cfg_start=1:
  - cfg_period==0: pulse cfg_error, stay IDLE.
  - Otherwise: latch period, clear tick_count to 0, go to WR_PL.
- WR_PL: write addr 2 = period[15:0]. Then WR_PH.
- WR_PH: write addr 3 = period[31:16]. Then WR_CTRL.
- WR_CTRL: write addr 1 = 0x0007 (CONTINUOUS=1) or 0x0005 (CONTINUOUS=0), i.e. START|ITO[|CONT]. Then RUN.
- RUN (no bus activity), evaluated in this priority order:
  - cfg_stop=1 → WR_STOP.
  - Else irq_in=1 → CLR_ST.
  - cfg_start in RUN is ignored.
- CLR_ST: write addr 0 = 0x0000. Same cycle: tick_pulse=1, tick_count+1 (modulo 2^TICK_W). Next state: RUN (CONTINUOUS=1) or CLR_FINAL-free return to IDLE (CONTINUOUS=0).
- WR_STOP: write addr 1 = 0x0008 (STOP, ITO cleared). Then CLR_FINAL.
- CLR_FINAL: write addr 0 = 0x0000. No tick counted. Then IDLE.
- Total latency, accepted cfg_start → RUN: 4 clk. Ticks cannot be serviced before the first RUN cycle.
- irq is cleared by the slave on the CLR_ST edge, so re-entry into RUN sees irq_in=0 unless a new timeout is pending.
- A timeout coinciding with the status write is lost (slave clear wins). This is accepted behaviour; minimum supported period is 2.
- cfg_stop while not in RUN is ignored. Stop requested during WR_* completes programming first, then is honoured on the first RUN cycle if still high.
- tick_count holds its value in IDLE until the next accepted start.

Optional Feature:
Macro TIMER_HOST_SNAP_EN adds snapshot readback. Ports snap_req (in, 1), snap_valid (out, 1) and snap_value (out, 32) always exist.
- With macro:
  - In RUN, priority is cfg_stop > irq_in > snap_req.
  - snap_req=1 runs three states:
    - SNAP_WR: write addr 4, data 0.
    - SNAP_RL: read addr 4 (chipselect 1, write_n 1).
    - SNAP_RH: read addr 5 and capture m_readdata into low half.
  - Following cycle (back in RUN): capture high half, pulse snap_valid.
  - snap_value holds until the next snapshot.
  - An irq arriving mid-snapshot is serviced after return to RUN.
- Without macro: snap_req ignored; snap_valid=0 and snap_value=0 permanently.

Test Plan:
1. cfg_period=0x0001_86A0, cfg_start pulse → writes (2,0x86A0), (3,0x0001), (1,0x0007) on 3 consecutive clk; busy=1 from the next clk.
2. Model slave raises irq 3 times, holding until status write → 3 writes (0,0x0000), 3 tick_pulse, tick_count=3, irq low in the cycle after each clear.
3. cfg_stop and irq_in both high in RUN → (1,0x0008) then (0,0x0000), no tick_pulse, tick_count unchanged, IDLE, busy=0.
4. cfg_period=0 with cfg_start → cfg_error one cycle, no bus activity, busy stays 0.
5. TICK_W=4: 17 timeouts → tick_count=1 (wrap at 15→0). CONTINUOUS=0: control write 0x0005, IDLE after one tick.
6. With TIMER_HOST_SNAP_EN, slave snapshot 0x1234_5678, snap_req → write addr 4, reads addr 4/5, snap_value=0x12345678, snap_valid one cycle. Without the macro: no bus activity, snap_valid=0.
